// File: rtl/nfu2_accum_ctrl.sv
// NFU-2 partial-sum accumulation controller: collects a programmed number of
// adder-tree tiles per output group and then hands the finished group to NFU-3.

module nfu2_accum_lane #(
   parameter int BIT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 acc_clr,
   input  logic                 acc_ld,
   input  logic                 out_ld,
   input  logic [BIT_WIDTH-1:0] din,
   output logic [BIT_WIDTH-1:0] acc,
   output logic [BIT_WIDTH-1:0] out_data
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc      <= '0;
         out_data <= '0;
      end else begin
         if (acc_clr)     acc <= '0;
         else if (acc_ld) acc <= din;
         if (out_ld) out_data <= din;
      end
   end
endmodule

module nfu2_accum_ctrl #(
   parameter int BIT_WIDTH = 16,
   parameter int Tn        = 16,
   parameter int CNT_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_start,
   input  logic [CNT_WIDTH-1:0]    i_num_iters,
   input  logic                    i_nfu1_valid,
   output logic                    o_nfu1_ready,
   input  logic [BIT_WIDTH*Tn-1:0] i_nfu2_out,
   output logic [BIT_WIDTH*Tn-1:0] o_partial_sum,
   output logic                    o_out_valid,
   input  logic                    i_out_ready,
   output logic [BIT_WIDTH*Tn-1:0] o_out_data,
   output logic                    o_busy,
   output logic                    o_done,
   output logic [CNT_WIDTH-1:0]    o_iter_cnt
);
   typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

   localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

   state_t                             state, state_nxt;
   logic [CNT_WIDTH-1:0]               num_lat;
   logic                               start_go, start_zero, accept, last, handshake;
   logic [Tn-1:0][BIT_WIDTH-1:0]       din_lanes, acc_lanes, out_lanes;

   assign start_go   = (state == IDLE) && i_start && (i_num_iters != '0);
   assign start_zero = (state == IDLE) && i_start && (i_num_iters == '0);
   assign accept     = (state == ACCUM) && i_nfu1_valid;
   assign last       = accept && (o_iter_cnt == num_lat - ONE);
   assign handshake  = (state == OUTPUT) && i_out_ready;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_go)  state_nxt = ACCUM;
         ACCUM:   if (last)      state_nxt = OUTPUT;
         OUTPUT:  if (handshake) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         num_lat    <= '0;
         o_iter_cnt <= '0;
         o_done     <= 1'b0;
         o_busy     <= 1'b0;
      end else begin
         state  <= state_nxt;
         // Decoding the next state keeps o_busy aligned with the state register.
         o_busy <= (state_nxt != IDLE);
         o_done <= start_zero || handshake;
         if (start_go) begin
            num_lat    <= i_num_iters;
            o_iter_cnt <= '0;
         end else if (accept) begin
            o_iter_cnt <= o_iter_cnt + ONE;
         end
      end
   end

   assign din_lanes = i_nfu2_out;

   for (genvar g = 0; g < Tn; g++) begin : g_lane
      nfu2_accum_lane #(.BIT_WIDTH(BIT_WIDTH)) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .acc_clr  (start_go),
         .acc_ld   (accept),
         .out_ld   (last),
         .din      (din_lanes[g]),
         .acc      (acc_lanes[g]),
         .out_data (out_lanes[g])
      );
   end

   assign o_partial_sum = acc_lanes;
   assign o_out_data    = out_lanes;
   assign o_nfu1_ready  = (state == ACCUM);
   assign o_out_valid   = (state == OUTPUT);
endmodule
